// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A queue entry carries the fetch address alongside the returned word.
package fetch_pkg;

   localparam int unsigned INST_W  = 32;
   localparam int unsigned PC_W    = 32;
   localparam int unsigned PC_STEP = 4;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {pc, inst} entries; flush empties it and wins over push.
// The head is a read-mux of the storage array and is only meaningful when count > 0.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  fetch_entry_t               push_data,
   input  logic                       pop,
   output fetch_entry_t               head_c,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = 1'b0;
      do_push  = 1'b0;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         do_pop  = pop && (count_q != '0);
         do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
         if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_c = mem_q[rd_ptr_q];
   assign count  = count_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word reads,
// queues returned words with their PCs and restarts cleanly on a branch redirect.
module inst_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_resp_valid,
   input  logic [INST_W-1:0] imem_resp_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned SUM_W = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]  outstanding_q, outstanding_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

   logic              credit_ok;
   logic              req_fire;
   logic              resp_ok;
   logic              push_c;
   logic              pop_c;
   logic [ADDR_W-1:0] target_pc;
   fetch_entry_t      push_entry;
   fetch_entry_t      head;
   logic [CNT_W-1:0]  fifo_count;
   logic [1:0]        unused_redirect_lsb;

   assign unused_redirect_lsb = redirect_pc[1:0];
   assign target_pc           = {redirect_pc[ADDR_W-1:2], 2'b00};

   // Queued plus in-flight words never exceed the queue size, so every response has a slot.
   assign credit_ok      = (SUM_W'(fifo_count) + SUM_W'(outstanding_q)) < SUM_W'(DEPTH);
   assign imem_req_valid = !reset && !redirect_valid && credit_ok;
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;
   assign resp_ok        = imem_resp_valid && (outstanding_q != '0);

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      resp_pc_d     = resp_pc_q;
      drop_cnt_d    = drop_cnt_q;
      outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_ok);
      push_c        = 1'b0;
      if (redirect_valid) begin
         // Everything still in flight after this cycle belongs to the abandoned path.
         fetch_pc_d = target_pc;
         resp_pc_d  = target_pc;
         drop_cnt_d = outstanding_q - CNT_W'(resp_ok);
      end else begin
         if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
         end
         if (resp_ok) begin
            if (drop_cnt_q != '0) begin
               drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end else begin
               push_c    = 1'b1;
               resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   always_comb begin
      push_entry.pc   = PC_W'(resp_pc_q);
      push_entry.inst = imem_resp_data;
   end

   assign pop_c = out_valid && out_ready;

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (redirect_valid),
      .push     (push_c),
      .push_data(push_entry),
      .pop      (pop_c),
      .head_c   (head),
      .count    (fifo_count)
   );

   // Head fields are masked to zero while the queue is empty.
   always_comb begin
      out_valid = (fifo_count != '0);
      out_inst  = '0;
      out_pc    = '0;
      if (out_valid) begin
         out_inst = head.inst;
         out_pc   = ADDR_W'(head.pc);
      end
   end

   resp_without_request_a: assert property (@(posedge clk) disable iff (reset)
      !(imem_resp_valid && (outstanding_q == '0)));

   outstanding_bound_a: assert property (@(posedge clk) disable iff (reset)
      (outstanding_q <= CNT_W'(DEPTH)) && (drop_cnt_q <= CNT_W'(DEPTH)));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: cycle table plus hand sequences for
// latency, redirect, wrap-around and asynchronous reset corners.
module tb_inst_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;

   inst_fetch_unit dut (
      .clk            (clk),
      .reset          (reset),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   typedef struct {
      logic        redir;
      logic [31:0] rpc;
      logic        ordy;
      logic        exp_rv;
      logic [31:0] exp_ra;
      logic        exp_ov;
      logic [31:0] exp_op;
   } vec_t;

   req_t        pend[$];
   vec_t        vq[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_inst[$];
   int          cyc;
   int          lat;
   int          n_req;
   int          n_vec;
   int          n_mis;

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return 32'hE3A00001 + {2'b00, a[31:2]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic redir, input logic [31:0] rpc, input logic ordy,
                      input logic rv, input logic [31:0] ra, input logic ov,
                      input logic [31:0] op);
      vec_t v;
      v.redir = redir; v.rpc = rpc; v.ordy = ordy;
      v.exp_rv = rv; v.exp_ra = ra; v.exp_ov = ov; v.exp_op = op;
      vq.push_back(v);
   endtask

   // Memory model: drive this cycle's response, then let outputs settle.
   task automatic drive_half();
      if (pend.size() != 0 && pend[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = mdata(pend[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = '0;
      end
      #1;
   endtask

   task automatic finish_half();
      req_t r;
      if (imem_resp_valid) void'(pend.pop_front());
      if (imem_req_valid && imem_req_ready) begin
         r.addr = imem_req_addr;
         r.due  = cyc + lat;
         pend.push_back(r);
         n_req++;
      end
      if (out_valid && out_ready) begin
         got_pc.push_back(out_pc);
         got_inst.push_back(out_inst);
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         drive_half();
         finish_half();
      end
   endtask

   task automatic run_until(input int need, input int budget);
      for (int k = 0; k < budget && got_pc.size() < need; k++) begin
         drive_half();
         finish_half();
      end
   endtask

   task automatic check_got(input string name, input int idx, input logic [31:0] exp_pc);
      if (idx >= got_pc.size()) begin
         chk({name, "_missing"}, 32'(got_pc.size()), 32'(idx + 1));
      end else begin
         chk({name, "_pc"}, got_pc[idx], exp_pc);
         chk({name, "_inst"}, got_inst[idx], mdata(exp_pc));
      end
   endtask

   task automatic do_reset(input int l);
      reset           = 1'b1;
      imem_resp_valid = 1'b0;
      redirect_valid  = 1'b0;
      pend.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      lat   = l;
      cyc   = 0;
      n_req = 0;
      got_pc.delete();
      got_inst.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_vec = 0; n_mis = 0; lat = 1; cyc = 0; n_req = 0;
      reset = 1'b1; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
      redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      #1;
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_req_addr", imem_req_addr, 32'h0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_inst", out_inst, 32'h0);
      chk("rst_out_pc", out_pc, 32'h0);

      // Cycle table, L=1: stream, stall with full queue, drain, redirect with pop+response.
      add(0, 0, 1, 1, 32'h00, 0, 32'h00);
      add(0, 0, 1, 1, 32'h04, 0, 32'h00);
      add(0, 0, 1, 1, 32'h08, 1, 32'h00);
      add(0, 0, 1, 1, 32'h0C, 1, 32'h04);
      add(0, 0, 1, 1, 32'h10, 1, 32'h08);
      add(0, 0, 1, 1, 32'h14, 1, 32'h0C);
      add(0, 0, 0, 1, 32'h18, 1, 32'h10);
      add(0, 0, 0, 1, 32'h1C, 1, 32'h10);
      add(0, 0, 0, 0, 32'h20, 1, 32'h10);
      add(0, 0, 0, 0, 32'h20, 1, 32'h10);
      add(0, 0, 0, 0, 32'h20, 1, 32'h10);
      add(0, 0, 1, 0, 32'h20, 1, 32'h10);
      add(0, 0, 1, 1, 32'h20, 1, 32'h14);
      add(0, 0, 1, 1, 32'h24, 1, 32'h18);
      add(0, 0, 1, 1, 32'h28, 1, 32'h1C);
      add(0, 0, 1, 1, 32'h2C, 1, 32'h20);
      add(1, 32'h103, 1, 0, 32'h30, 1, 32'h24);
      add(0, 0, 1, 1, 32'h100, 0, 32'h00);
      add(0, 0, 1, 1, 32'h104, 0, 32'h00);
      add(0, 0, 1, 1, 32'h108, 1, 32'h100);
      add(0, 0, 1, 1, 32'h10C, 1, 32'h104);

      do_reset(1);
      for (int i = 0; i < vq.size(); i++) begin
         redirect_valid = vq[i].redir;
         redirect_pc    = vq[i].rpc;
         out_ready      = vq[i].ordy;
         drive_half();
         chk($sformatf("row%0d_req_valid", i), 32'(imem_req_valid), 32'(vq[i].exp_rv));
         chk($sformatf("row%0d_req_addr", i), imem_req_addr, vq[i].exp_ra);
         chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(vq[i].exp_ov));
         chk($sformatf("row%0d_out_pc", i), out_pc, vq[i].exp_op);
         chk($sformatf("row%0d_out_inst", i), out_inst,
             vq[i].exp_ov ? mdata(vq[i].exp_op) : 32'h0);
         finish_half();
      end
      redirect_valid = 1'b0;

      // L=3: redirect with three requests in flight; all late words are dropped.
      do_reset(3);
      out_ready = 1'b1;
      step(3);
      redirect_valid = 1'b1; redirect_pc = 32'h103;
      step(1);
      redirect_valid = 1'b0;
      run_until(2, 30);
      check_got("l3_first", 0, 32'h100);
      check_got("l3_second", 1, 32'h104);

      // L=2: redirect coincides with a response and a pop.
      do_reset(2);
      out_ready = 1'b1;
      step(8);
      redirect_valid = 1'b1; redirect_pc = 32'h200;
      drive_half();
      chk("l2_redir_out_valid", 32'(out_valid), 32'd1);
      chk("l2_redir_resp_valid", 32'(imem_resp_valid), 32'd1);
      finish_half();
      redirect_valid = 1'b0;
      run_until(9, 30);
      for (int i = 0; i < 6; i++) check_got($sformatf("l2_old%0d", i), i, 32'(4 * i));
      check_got("l2_new0", 6, 32'h200);
      check_got("l2_new1", 7, 32'h204);
      check_got("l2_new2", 8, 32'h208);

      // Fetch PC wraps past the top of the address space.
      do_reset(1);
      out_ready = 1'b1;
      step(2);
      redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      step(1);
      redirect_valid = 1'b0;
      got_pc.delete(); got_inst.delete();
      run_until(2, 20);
      check_got("wrap_top", 0, 32'hFFFF_FFFC);
      check_got("wrap_zero", 1, 32'h0000_0000);

      // Stall: exactly DEPTH requests, then drain in order.
      do_reset(1);
      out_ready = 1'b0;
      step(10);
      drive_half();
      chk("stall_req_count", 32'(n_req), 32'd4);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall_head_pc", out_pc, 32'h0);
      out_ready = 1'b1;
      finish_half();
      run_until(4, 20);
      for (int i = 0; i < 4; i++) check_got($sformatf("drain%0d", i), i, 32'(4 * i));

      // Refill, then hit reset between edges with the queue full.
      out_ready = 1'b0;
      step(8);
      chk("full_out_valid", 32'(out_valid), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("async_out_valid", 32'(out_valid), 32'd0);
      chk("async_req_valid", 32'(imem_req_valid), 32'd0);
      chk("async_req_addr", imem_req_addr, 32'h0);
      chk("async_out_pc", out_pc, 32'h0);
      chk("async_out_inst", out_inst, 32'h0);
      imem_resp_valid = 1'b0;
      pend.delete();
      @(negedge clk);
      reset = 1'b0; cyc = 0; n_req = 0;
      got_pc.delete(); got_inst.delete();
      out_ready = 1'b1;
      drive_half();
      chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
      chk("restart_req_addr", imem_req_addr, 32'h0);
      finish_half();
      run_until(2, 20);
      check_got("restart0", 0, 32'h0);
      check_got("restart1", 1, 32'h4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage directly upstream of the `processor` core. It owns the fetch PC, issues word reads to the instruction memory (fixed or variable latency, in-order responses), and buffers returned words with their PCs in a small prefetch queue. It presents `{pc, inst}` pairs to the core's decode input over a valid/ready handshake. A branch redirect from the core flushes the queue, discards in-flight responses and restarts fetch at the new target.

## Interface
- `ADDR_W`, 32: width of fetch PC and memory address.
- `DEPTH`, 4: prefetch queue entries (power of two, ≥2); also the maximum number of outstanding memory requests.
- `RESET_PC`, 32'h0: first fetch address after reset.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `imem_req_valid`  out  1  read request valid.
- `imem_req_addr`  out  ADDR_W  word-aligned read address.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_resp_valid`  in  1  read data valid (in request order, ≥1 cycle after acceptance).
- `imem_resp_data`  in  32  instruction word.
- `redirect_valid`  in  1  core requests fetch restart.
- `redirect_pc`  in  ADDR_W  restart target; bits [1:0] ignored (forced 0).
- `out_valid`  out  1  queue head valid.
- `out_ready`  in  1  core accepts the head.
- `out_inst`  out  32  head instruction.
- `out_pc`  out  ADDR_W  PC of head instruction.

## Operation
- Reset state: `fetch_pc`=RESET_PC, queue empty, `outstanding`=0, `drop_cnt`=0. Outputs during reset: `imem_req_valid`=0, `imem_req_addr`=RESET_PC, `out_valid`=0, `out_inst`=0, `out_pc`=0.
- Credit rule: `imem_req_valid` = !redirect_valid && (count + outstanding < DEPTH). `imem_req_addr` = `fetch_pc`.
- Request accepted (valid && ready): `fetch_pc` += 4, modulo 2^ADDR_W (wraps to 0 silently); `outstanding` += 1.
- Response: `outstanding` -= 1. If `drop_cnt` > 0, the word is discarded and `drop_cnt` -= 1. Otherwise, `{fetch address, data}` is pushed to the queue. The address is tracked by a shadow `resp_pc` register that advances by 4 per kept response.
- Pop: `out_valid && out_ready` removes the head. A push and a pop in the same cycle leave the count unchanged, including when the queue is full.
- Redirect (highest priority):
  - queue cleared;
  - `fetch_pc` and `resp_pc` set to `{redirect_pc[ADDR_W-1:2],2'b00}`;
  - `drop_cnt` = `outstanding` after this cycle's response is counted, so a response arriving in the redirect cycle is also dropped;
  - no request is issued that cycle.
- A pop handshake in the redirect cycle still completes; the core owns that word. Back-to-back redirects are each honoured; the last one wins.
- `outstanding` and `drop_cnt` never exceed DEPTH. A response with `outstanding`=0 is a protocol error: ignored, assertion fires.

## Timing
- Request issue is combinational from registered state. Response to queue takes one register stage.
- Latency, memory latency L (accept at edge N, response valid in cycle N+L): `out_valid` rises in cycle N+L+1.
- After reset release with L=1: request in cycle 0, `out_valid`=1 in cycle 2 with `out_pc`=RESET_PC.
- Redirect in cycle R: `out_valid`=0 in cycle R+1; first target request in cycle R+1; target word visible at R+1+L+1.
- Sustained throughput is 1 instr/cycle when L+1 ≤ DEPTH and `out_ready` is held high.
- Reset asserted mid-operation clears all state immediately. Responses to pre-reset requests are the memory's responsibility; the memory is reset together with this block.

## Structure
- Package `fetch_pkg`: `INST_W`=32, typedef `fetch_entry_t` {pc, inst}, constant `PC_STEP`=4.
- Sub-module `fetch_fifo`: synchronous FIFO of `fetch_entry_t` with depth DEPTH, a flush input, and push/pop/count. Flush has priority over push.
- Top level holds `fetch_pc`, `resp_pc`, the `outstanding` and `drop_cnt` counters, and the credit logic.

## Test plan
- Reset release, L=1, `out_ready`=1, memory holds 0xE3A00001.. at 0x0..: out sequence pc 0x0, 0x4, 0x8, one per cycle from cycle 2 onward, data matches.
- `out_ready`=0 for 10 cycles: exactly DEPTH=4 requests issued, then `imem_req_valid`=0. When ready is raised, the words at PCs 0x0–0xC drain in order with none lost.
- L=3, redirect to 0x103 while 3 requests are in flight: the 3 late responses are dropped, and the next `out_pc`=0x100.
- Redirect in the same cycle as a response and a pop: the popped word is delivered, the response is dropped, and `drop_cnt` is correct, so the first kept word is the target's.
- Set `fetch_pc` near the top via redirect to 0xFFFFFFFC: the out PCs are 0xFFFFFFFC then 0x00000000.
- Assert `reset` asynchronously mid-stream with the queue full: all outputs return to reset values before the next edge, and fetch restarts at RESET_PC.
